fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 95 +++++++++
 tb/tb_fetch_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: a PC register driving instruction memory and a
// circular prefetch queue of {instr, pc_plus4} entries feeding decode.
module fetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_en,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     dec_ready,
  output logic                     out_valid,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [ADDR_W-1:0]        out_pc_plus4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [PTR_W-1:0]   head_reg, head_next;
  logic [PTR_W-1:0]   tail_reg, tail_next;
  logic [CNT_W-1:0]   count_reg, count_next;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc4_mem   [DEPTH];

  logic [ADDR_W-1:0]  pc_plus4;
  logic               full;
  logic               pop;
  logic               push;

  assign pc_plus4 = pc_reg + ADDR_W'(4);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign pop      = out_valid & dec_ready;
  // A pop frees the head slot at the same edge, so a full queue can still accept.
  assign push     = fetch_en & ~redirect & (~full | pop);

  always_comb begin
    pc_next    = pc_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (redirect) begin
      pc_next    = redirect_pc;
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push) begin
        tail_next = tail_reg + PTR_W'(1);
        pc_next   = pc_plus4;
      end
      if (pop) begin
        head_next = head_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      pc_reg    <= pc_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entry storage needs no reset: stale slots are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_reg] <= imem_rdata;
      pc4_mem[tail_reg]   <= pc_plus4;
    end
  end

  assign imem_addr    = pc_reg;
  assign count        = count_reg;
  assign out_valid    = (count_reg != '0);
  assign out_instr    = out_valid ? instr_mem[head_reg] : '0;
  assign out_pc_plus4 = out_valid ? pc4_mem[head_reg]   : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboarded bench for fetch_queue: directed phases queue the expected
// instruction stream, a negedge monitor checks every entry decode accepts.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dec_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic [2:0]  count;

  // Narrow-address instance for PC wrap-around.
  logic        fetch_en8;
  logic [7:0]  imem_addr8;
  logic [31:0] imem_rdata8;
  logic        out_valid8;
  logic [31:0] out_instr8;
  logic [7:0]  out_pc_plus48;
  logic [2:0]  count8;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  assign imem_rdata  = word(imem_addr);
  assign imem_rdata8 = word({24'h0, imem_addr8});

  fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dec_ready(dec_ready), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc_plus4(out_pc_plus4), .count(count)
  );

  fetch_queue #(.ADDR_W(8), .INSTR_W(32), .DEPTH(4), .RESET_PC(8'hFC)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en8), .redirect(1'b0),
    .redirect_pc(8'h00), .imem_addr(imem_addr8), .imem_rdata(imem_rdata8),
    .dec_ready(1'b0), .out_valid(out_valid8), .out_instr(out_instr8),
    .out_pc_plus4(out_pc_plus48), .count(count8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head entry must match the oldest expected PC.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && dec_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_pop: got instr 0x%0h, expected no entry", out_instr);
      end else begin
        logic [31:0] pc;
        pc = exp_q.pop_front();
        check("pop_instr", {32'h0, out_instr}, {32'h0, word(pc)});
        check("pop_pc_plus4", {32'h0, out_pc_plus4}, {32'h0, pc + 32'd4});
      end
    end
  end

  initial begin
    rst_n       = 1'b1;
    fetch_en    = 1'b0;
    fetch_en8   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    dec_ready   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", {63'h0, out_valid}, 64'h0);
    check("rst_count", {61'h0, count}, 64'h0);
    check("rst_instr", {32'h0, out_instr}, 64'h0);
    check("rst_imem_addr", {32'h0, imem_addr}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with decode always ready: one entry in flight.
    fetch_en  = 1'b1;
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'(i * 4));
      step();
      check("stream_count", {61'h0, count}, 64'd1);
    end
    fetch_en = 1'b0;
    step();
    check("drain_count", {61'h0, count}, 64'd0);

    // Restart at 0 so the fill phase matches the classic numbers.
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    fetch_en    = 1'b1;
    dec_ready   = 1'b0;
    step();
    redirect = 1'b0;
    check("redir0_addr", {32'h0, imem_addr}, 64'h0);

    // Fill with decode stalled: saturates at 4, PC stalls at 0x10.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back(32'(i * 4));
      step();
      check("fill_count", {61'h0, count}, (i < 3) ? 64'(i + 1) : 64'd4);
    end
    check("stall_pc", {32'h0, imem_addr}, 64'h10);
    check("stall_head", {32'h0, out_instr}, {32'h0, word(32'h0)});

    // Push-through while full.
    dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(32'h10 + 32'(i * 4));
      step();
      check("full_pt_count", {61'h0, count}, 64'd4);
    end
    check("full_pt_pc", {32'h0, imem_addr}, 64'h24);

    // Redirect with three entries queued; the head popped that cycle still counts.
    fetch_en = 1'b0;
    step();
    check("pre_redir_count", {61'h0, count}, 64'd3);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    fetch_en    = 1'b1;
    step();
    exp_q.delete();
    redirect  = 1'b0;
    dec_ready = 1'b0;
    check("redir_count", {61'h0, count}, 64'd0);
    check("redir_valid", {63'h0, out_valid}, 64'h0);
    check("redir_addr", {32'h0, imem_addr}, 64'h100);
    exp_q.push_back(32'h100);
    step();
    check("redir_fetch_count", {61'h0, count}, 64'd1);
    check("redir_fetch_instr", {32'h0, out_instr}, {32'h0, word(32'h100)});
    check("redir_fetch_pc4", {32'h0, out_pc_plus4}, 64'h104);
    exp_q.push_back(32'h104);
    step();
    check("pre_rst_count", {61'h0, count}, 64'd2);

    // Asynchronous reset between edges with two entries queued.
    #3 rst_n = 1'b0;
    fetch_en = 1'b0;
    #1;
    exp_q.delete();
    check("arst_valid", {63'h0, out_valid}, 64'h0);
    check("arst_count", {61'h0, count}, 64'd0);
    check("arst_instr", {32'h0, out_instr}, 64'h0);
    check("arst_pc4", {32'h0, out_pc_plus4}, 64'h0);
    check("arst_addr", {32'h0, imem_addr}, 64'h0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_addr", {32'h0, imem_addr}, 64'h0);
    check("idle_count", {61'h0, count}, 64'd0);
    fetch_en  = 1'b1;
    dec_ready = 1'b1;
    exp_q.push_back(32'h0);
    step();
    exp_q.push_back(32'h4);
    step();
    fetch_en = 1'b0;
    step();
    check("post_rst_count", {61'h0, count}, 64'd0);

    // 8-bit PC wraps from 0xFC to 0x00.
    check("wrap_start_pc", {56'h0, imem_addr8}, 64'hFC);
    fetch_en8 = 1'b1;
    step();
    fetch_en8 = 1'b0;
    check("wrap_pc", {56'h0, imem_addr8}, 64'h00);
    check("wrap_pc4", {56'h0, out_pc_plus48}, 64'h00);
    check("wrap_instr", {32'h0, out_instr8}, {32'h0, word(32'hFC)});
    check("wrap_count", {61'h0, count8}, 64'd1);

    step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
